// File: rtl/step_cmd_gen.sv
// Up/down step command generator: synchronizes and debounces two buttons, then issues
// one-cycle step strobes with hold-to-repeat and a lockout while both buttons are pressed.
module step_cmd_gen #(
   parameter int DB_CYCLES     = 4,
   parameter int HOLD_CYCLES   = 20,
   parameter int REPEAT_CYCLES = 8
) (
   input  logic Clk,
   input  logic nReset,
   input  logic BtnUp,
   input  logic BtnDown,
   output logic Enable,
   output logic Up,
   output logic Locked
);

   localparam int DB_W    = $clog2(DB_CYCLES + 1);
   localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
   localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES);
   localparam logic [TMR_W-1:0] REP_LD  = TMR_W'(REPEAT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2,
      S_LOCK   = 2'd3
   } state_t;

   // Bit 1 carries the up button, bit 0 the down button throughout.
   logic [1:0]           btn_raw;
   logic [1:0]           btn_p0;
   logic [1:0]           btn_p1;
   logic [1:0]           deb;
   logic [1:0]           deb_d;
   logic [1:0][DB_W-1:0] db_cnt;
   logic [1:0]           press;

   state_t               state;
   state_t               state_nxt;
   logic [TMR_W-1:0]     tmr;
   logic [TMR_W-1:0]     tmr_nxt;
   logic                 step;
   logic                 step_up;
   logic                 held;
   logic                 both;
   logic                 tmr_done;
   logic                 start_up;
   logic                 start_dn;

   assign btn_raw = {BtnUp, BtnDown};

   // Stage p0/p1: two-flop synchronizer
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         btn_p0 <= '0;
         btn_p1 <= '0;
      end else begin
         btn_p0 <= btn_raw;
         btn_p1 <= btn_p0;
      end
   end

   // Debounce: level flips once the synchronized input has disagreed for DB_CYCLES edges
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         deb    <= '0;
         deb_d  <= '0;
         db_cnt <= '0;
      end else begin
         deb_d <= deb;
         for (int i = 0; i < 2; i++) begin
            if (btn_p1[i] != deb[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  deb[i]    <= ~deb[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign press    = deb & ~deb_d;
   assign both     = &deb;
   assign start_up = press[1] && !deb[0];
   assign start_dn = press[0] && !deb[1];
   // Up already holds the direction of the button being held in HOLD/REPEAT.
   assign held     = Up ? deb[1] : deb[0];
   // Never strobe on back-to-back cycles, even with a one-cycle repeat period.
   assign tmr_done = (tmr <= TMR_ONE) && !Enable;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (both) begin
         state_nxt = S_LOCK;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_up || start_dn) state_nxt = S_HOLD;
            end
            S_HOLD: begin
               if (!held)         state_nxt = S_IDLE;
               else if (tmr_done) state_nxt = S_REPEAT;
            end
            S_REPEAT: begin
               if (!held) state_nxt = S_IDLE;
            end
            S_LOCK: begin
               if (deb == 2'b00) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      step    = 1'b0;
      step_up = Up;
      tmr_nxt = '0;
      if (!both) begin
         case (state)
            S_IDLE: begin
               if (start_up) begin
                  step    = 1'b1;
                  step_up = 1'b1;
                  tmr_nxt = HOLD_LD;
               end else if (start_dn) begin
                  step    = 1'b1;
                  step_up = 1'b0;
                  tmr_nxt = HOLD_LD;
               end
            end
            S_HOLD, S_REPEAT: begin
               if (held) begin
                  if (tmr_done) begin
                     step    = 1'b1;
                     tmr_nxt = REP_LD;
                  end else if (tmr > TMR_ONE) begin
                     tmr_nxt = tmr - 1'b1;
                  end else begin
                     tmr_nxt = tmr;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Registered outputs and timer
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         tmr    <= '0;
         Enable <= 1'b0;
         Up     <= 1'b1;
         Locked <= 1'b0;
      end else begin
         tmr    <= tmr_nxt;
         Enable <= step;
         if (step) Up <= step_up;
         Locked <= (state_nxt == S_LOCK);
      end
   end

endmodule

// File: tb/tb_step_cmd_gen.sv
// Scoreboard bench for step_cmd_gen: a time-based reference model predicts step cycles,
// a monitor pops and compares them whenever Enable is seen.
module tb_step_cmd_gen;

   localparam int DB   = 4;
   localparam int HOLD = 20;
   localparam int REP  = 8;

   localparam int M_IDLE   = 0;
   localparam int M_ACTIVE = 1;
   localparam int M_LOCK   = 2;

   logic Clk     = 1'b0;
   logic nReset  = 1'b0;
   logic BtnUp   = 1'b0;
   logic BtnDown = 1'b0;
   logic Enable;
   logic Up;
   logic Locked;

   step_cmd_gen #(
      .DB_CYCLES    (DB),
      .HOLD_CYCLES  (HOLD),
      .REPEAT_CYCLES(REP)
   ) dut (
      .Clk    (Clk),
      .nReset (nReset),
      .BtnUp  (BtnUp),
      .BtnDown(BtnDown),
      .Enable (Enable),
      .Up     (Up),
      .Locked (Locked)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int   cyc;
      logic up;
   } step_t;

   step_t exp_q[$];
   int    steps_seen[$];
   int    tests    = 0;
   int    fails    = 0;
   int    cyc      = 0;
   int    en_count = 0;
   logic  last_up  = 1'b1;
   logic  en_prev  = 1'b0;

   // Reference model state: synchronizer view, debounced levels, mode and step schedule.
   logic [1:0] m_s1, m_s2, m_deb, m_deb_d;
   int         m_run[2];
   int         m_mode;
   int         m_next;
   logic       m_dir;
   logic       m_locked;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
      end
   endtask

   task automatic model_reset();
      m_s1     = '0;
      m_s2     = '0;
      m_deb    = '0;
      m_deb_d  = '0;
      m_run[0] = 0;
      m_run[1] = 0;
      m_mode   = M_IDLE;
      m_next   = 0;
      m_dir    = 1'b1;
      m_locked = 1'b0;
   endtask

   task automatic issue(input logic d);
      step_t e;
      e.cyc = cyc;
      e.up  = d;
      exp_q.push_back(e);
      m_dir = d;
   endtask

   task automatic model_step();
      logic [1:0] raw;
      logic [1:0] press;
      logic [1:0] nd;
      raw   = {BtnUp, BtnDown};
      press = m_deb & ~m_deb_d;
      if (m_deb == 2'b11) begin
         m_mode = M_LOCK;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (press[1] && !m_deb[0]) begin
                  issue(1'b1);
                  m_mode = M_ACTIVE;
                  m_next = cyc + HOLD;
               end else if (press[0] && !m_deb[1]) begin
                  issue(1'b0);
                  m_mode = M_ACTIVE;
                  m_next = cyc + HOLD;
               end
            end
            M_ACTIVE: begin
               if (!(m_dir ? m_deb[1] : m_deb[0])) begin
                  m_mode = M_IDLE;
               end else if (cyc == m_next) begin
                  issue(m_dir);
                  m_next = cyc + REP;
               end
            end
            default: begin
               if (m_deb == 2'b00) m_mode = M_IDLE;
            end
         endcase
      end
      m_locked = (m_mode == M_LOCK);
      nd = m_deb;
      for (int i = 0; i < 2; i++) begin
         if (m_s2[i] != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               nd[i]    = ~nd[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_deb_d = m_deb;
      m_deb   = nd;
      m_s2    = m_s1;
      m_s1    = raw;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge Clk);
         cyc++;
         if (!nReset) model_reset();
         else model_step();
      end
   end

   // Monitor: samples 1 time unit after each rising edge
   initial begin
      forever begin
         @(posedge Clk);
         #1;
         if (Enable === 1'b1) begin
            en_count++;
            steps_seen.push_back(cyc);
            last_up = Up;
            chk("en_gap", {31'd0, en_prev}, 32'd0);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_step cyc=%0d actual=Enable required=no_step Up=%0b", cyc, Up);
            end else begin
               step_t e;
               e = exp_q.pop_front();
               chk("step_cycle", cyc, e.cyc);
               chk("step_dir", {31'd0, Up}, {31'd0, e.up});
            end
         end
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            step_t m;
            m = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_step cyc=%0d actual=no_step required=step_at_%0d", cyc, m.cyc);
         end
         chk("locked", {31'd0, Locked}, {31'd0, m_locked});
         chk("up_hold", {31'd0, Up}, {31'd0, m_dir});
         en_prev = Enable;
      end
   end

   task automatic apply(input logic u, input logic d, input int n);
      @(posedge Clk);
      #3;
      BtnUp   = u;
      BtnDown = d;
      if (n > 1) repeat (n - 1) @(posedge Clk);
   endtask

   initial begin
      int   base;
      int   t_set;
      logic up_before;

      // Reset state
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_enable", {31'd0, Enable}, 32'd0);
      chk("rst_up", {31'd0, Up}, 32'd1);
      chk("rst_locked", {31'd0, Locked}, 32'd0);
      #2;
      nReset = 1'b1;
      apply(0, 0, 5);

      // Clean up press, 10 cycles
      base = en_count;
      steps_seen.delete();
      @(posedge Clk); #3; t_set = cyc; BtnUp = 1'b1;
      repeat (9) @(posedge Clk);
      apply(0, 0, 25);
      chk("clean_count", en_count - base, 32'd1);
      if (steps_seen.size() > 0) chk("clean_latency", steps_seen[0] - t_set, 32'd7);
      chk("clean_dir", {31'd0, last_up}, 32'd1);

      // Bouncing down button, then steady
      base = en_count;
      steps_seen.delete();
      for (int i = 0; i < 3; i++) begin
         apply(0, 1, 2);
         apply(0, 0, 2);
      end
      @(posedge Clk); #3; t_set = cyc; BtnDown = 1'b1;
      repeat (19) @(posedge Clk);
      apply(0, 0, 25);
      chk("bounce_count", en_count - base, 32'd1);
      if (steps_seen.size() > 0) chk("bounce_latency", steps_seen[0] - t_set, 32'd7);
      chk("bounce_dir", {31'd0, last_up}, 32'd0);

      // Up held 60 cycles: hold delay then auto-repeat
      base = en_count;
      steps_seen.delete();
      @(posedge Clk); #3; t_set = cyc; BtnUp = 1'b1;
      repeat (59) @(posedge Clk);
      apply(0, 0, 30);
      chk("repeat_count", en_count - base, 32'd6);
      if (steps_seen.size() >= 3) begin
         chk("repeat_first", steps_seen[0] - t_set, 32'd7);
         chk("repeat_hold_gap", steps_seen[1] - steps_seen[0], 32'd20);
         chk("repeat_gap", steps_seen[2] - steps_seen[1], 32'd8);
      end
      chk("repeat_dir", {31'd0, last_up}, 32'd1);

      // Simultaneous press -> lock
      base = en_count;
      apply(1, 1, 15);
      #1;
      chk("lock_both", {31'd0, Locked}, 32'd1);
      apply(0, 1, 15);
      #1;
      chk("lock_one_released", {31'd0, Locked}, 32'd1);
      apply(0, 0, 15);
      #1;
      chk("lock_released", {31'd0, Locked}, 32'd0);
      chk("lock_count", en_count - base, 32'd0);

      // Down held into repeat, then a one-cycle reset pulse
      apply(0, 1, 45);
      @(posedge Clk);
      #3;
      nReset = 1'b0;
      #1;
      chk("midrst_enable", {31'd0, Enable}, 32'd0);
      chk("midrst_up", {31'd0, Up}, 32'd1);
      @(posedge Clk);
      #3;
      nReset = 1'b1;
      base = en_count;
      apply(0, 1, 10);
      apply(0, 0, 25);
      chk("postrst_count", en_count - base, 32'd1);

      // 3-cycle glitch on up
      base = en_count;
      up_before = Up;
      apply(1, 0, 3);
      apply(0, 0, 20);
      chk("glitch_count", en_count - base, 32'd0);
      chk("glitch_up", {31'd0, Up}, {31'd0, up_before});

      // Random button activity
      for (int i = 0; i < 60; i++) begin
         apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 30));
      end
      apply(0, 0, 50);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
